counter_gen: RTL and testbench



---
 rtl/counter_pkg.sv | 16 +
 rtl/counter_next_calc.sv | 94 +++++++++
 rtl/counter_gen.sv | 64 ++++++
 tb/tb_counter_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared constants for the parametrised mode counter. The RTL, the checker and
// the scoreboard all import this package so that every party agrees on the
// mode encoding.
package counter_pkg;

    localparam logic [1:0] MODE_UP  = 2'b00;  // count up by 1
    localparam logic [1:0] MODE_DN  = 2'b01;  // count down by 1
    localparam logic [1:0] MODE_DNS = 2'b10;  // count down by STEP
    localparam logic [1:0] MODE_LD  = 2'b11;  // parallel load of D

    // True for the modes that advance the count (everything except load).
    function automatic logic is_count_mode(input logic [1:0] mode);
        return (mode != MODE_LD);
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-state logic for counter_gen: computes the next count,
// the ripple-carry and load-acknowledge values to be registered, and the
// unregistered lookahead carry used to chain instances.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             adv,
    input  logic             enable,
    output logic [WIDTH-1:0] q_next,
    output logic             rco_next,
    output logic             load_next,
    output logic             cout
);

    localparam logic [WIDTH-1:0] MAX    = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO   = '0;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
    localparam bit               SAT    = (SATURATE != 0);

    // One extra bit on the step subtraction: its MSB is the borrow, which
    // marks the Q < STEP case without a separate magnitude comparator.
    logic [WIDTH:0] dns_diff;
    logic           at_max;
    logic           at_zero;
    logic           below_step;
    logic           boundary;

    assign dns_diff   = {1'b0, q} - STEP_X;
    assign at_max     = (q == MAX);
    assign at_zero    = (q == ZERO);
    assign below_step = dns_diff[WIDTH];

    // Select the boundary condition relevant to the current counting mode.
    always_comb begin
        boundary = 1'b0;
        case (mode)
            MODE_UP:  boundary = at_max;
            MODE_DN:  boundary = at_zero;
            MODE_DNS: boundary = below_step;
            default:  boundary = 1'b0;
        endcase
    end

    // Lookahead carry: the next edge will wrap or clamp this stage.
    assign cout = adv & is_count_mode(mode) & boundary;

    // Next count, rco and load; load wins over counting and ignores cin.
    always_comb begin
        q_next    = q;
        rco_next  = 1'b0;
        load_next = 1'b0;
        if (enable && (mode == MODE_LD)) begin
            q_next    = d;
            load_next = 1'b1;
        end else if (adv) begin
            case (mode)
                MODE_UP: begin
                    if (at_max) begin
                        q_next   = SAT ? MAX : ZERO;
                        rco_next = 1'b1;
                    end else begin
                        q_next = q + ONE;
                    end
                end
                MODE_DN: begin
                    if (at_zero) begin
                        q_next   = SAT ? ZERO : MAX;
                        rco_next = 1'b1;
                    end else begin
                        q_next = q - ONE;
                    end
                end
                MODE_DNS: begin
                    if (below_step) begin
                        q_next   = SAT ? ZERO : dns_diff[WIDTH-1:0];
                        rco_next = 1'b1;
                    end else begin
                        q_next = dns_diff[WIDTH-1:0];
                    end
                end
                default: q_next = q;
            endcase
        end
    end

endmodule

// File: rtl/counter_gen.sv
// Parametrised up/down/down-by-STEP/load counter with wrap or saturate
// behaviour, cascade carry-in and lookahead carry-out. This level holds only
// the registers and the reset mux; all arithmetic lives in counter_next_calc.
module counter_gen
    import counter_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int STEP     = 3,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             cin,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             rco,
    output logic             load,
    output logic             cout
);

    logic             adv;
    logic [WIDTH-1:0] q_next;
    logic             rco_next;
    logic             load_next;
    logic             cout_calc;

    // A stage only advances when enabled and the lower stage carries in.
    assign adv = enable & cin;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .STEP     (STEP),
        .SATURATE (SATURATE)
    ) u_next (
        .q         (Q),
        .mode      (mode),
        .d         (D),
        .adv       (adv),
        .enable    (enable),
        .q_next    (q_next),
        .rco_next  (rco_next),
        .load_next (load_next),
        .cout      (cout_calc)
    );

    // Reset forces the lookahead carry low so an upper stage cannot move.
    assign cout = cout_calc & ~reset;

    // Register the count and the one-cycle rco/load pulses; reset dominates.
    always_ff @(posedge clk) begin
        if (reset) begin
            Q    <= '0;
            rco  <= 1'b0;
            load <= 1'b0;
        end else begin
            Q    <= q_next;
            rco  <= rco_next;
            load <= load_next;
        end
    end

endmodule

// File: tb/tb_counter_gen.sv
// Bench for counter_gen: a directed vector table on a WIDTH=4/STEP=3 wrapping
// instance, hand sequences for a saturating instance and a two-stage cascade,
// then randomized traffic checked against an arithmetic reference model.
module tb_counter_gen;
    import counter_pkg::*;

    localparam int MAXV = 15;

    // ---------------- clock ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main instance (wrap) ----------------
    logic       reset, enable, cin;
    logic [1:0] mode;
    logic [3:0] d, q;
    logic       rco, load, cout;

    counter_gen #(.WIDTH(4), .STEP(3), .SATURATE(0)) u_dut (
        .clk(clk), .reset(reset), .enable(enable), .cin(cin), .mode(mode),
        .D(d), .Q(q), .rco(rco), .load(load), .cout(cout)
    );

    // ---------------- saturating instance ----------------
    logic       s_reset, s_enable, s_cin;
    logic [1:0] s_mode;
    logic [3:0] s_d, s_q;
    logic       s_rco, s_load, s_cout;

    counter_gen #(.WIDTH(4), .STEP(3), .SATURATE(1)) u_sat (
        .clk(clk), .reset(s_reset), .enable(s_enable), .cin(s_cin), .mode(s_mode),
        .D(s_d), .Q(s_q), .rco(s_rco), .load(s_load), .cout(s_cout)
    );

    // ---------------- two-stage cascade ----------------
    logic       c_reset, c_enable;
    logic [1:0] c_mode;
    logic [7:0] c_d;
    logic [3:0] lo_q, hi_q;
    logic       lo_rco, hi_rco, lo_load, hi_load, lo_cout, hi_cout;

    counter_gen #(.WIDTH(4), .STEP(3), .SATURATE(0)) u_lo (
        .clk(clk), .reset(c_reset), .enable(c_enable), .cin(1'b1), .mode(c_mode),
        .D(c_d[3:0]), .Q(lo_q), .rco(lo_rco), .load(lo_load), .cout(lo_cout)
    );

    counter_gen #(.WIDTH(4), .STEP(1), .SATURATE(0)) u_hi (
        .clk(clk), .reset(c_reset), .enable(c_enable), .cin(lo_cout), .mode(c_mode),
        .D(c_d[7:4]), .Q(hi_q), .rco(hi_rco), .load(hi_load), .cout(hi_cout)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic void model_next(input int cur, input bit rst, input bit en, input bit ci,
                                       input int md, input int dv, input bit sat, input int stepv,
                                       output int nq, output bit nr, output bit nl);
        int t;
        nq = cur;
        nr = 1'b0;
        nl = 1'b0;
        if (rst) begin
            nq = 0;
            return;
        end
        if (!en) return;
        if (md == 3) begin
            nq = dv;
            nl = 1'b1;
            return;
        end
        if (!ci) return;
        t = cur + ((md == 0) ? 1 : (md == 1) ? -1 : -stepv);
        if (t > MAXV || t < 0) begin
            nr = 1'b1;
            if (sat) nq = (t > MAXV) ? MAXV : 0;
            else     nq = (t + MAXV + 1) % (MAXV + 1);
        end else begin
            nq = t;
        end
    endfunction

    function automatic bit model_cout(input int cur, input bit rst, input bit en, input bit ci,
                                      input int md, input int stepv);
        int t;
        if (rst || !en || !ci || md == 3) return 1'b0;
        t = cur + ((md == 0) ? 1 : (md == 1) ? -1 : -stepv);
        return (t > MAXV || t < 0);
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic       en;
        logic       ci;
        logic [1:0] md;
        logic [3:0] dv;
        logic [3:0] eq;
        logic       er;
        logic       el;
        logic       ec;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic en, input logic ci, input logic [1:0] md,
                                input logic [3:0] dv, input logic [3:0] eq, input logic er,
                                input logic el, input logic ec);
        vec_t v;
        v.rst = rst; v.en = en; v.ci = ci; v.md = md; v.dv = dv;
        v.eq = eq; v.er = er; v.el = el; v.ec = ec;
        tbl.push_back(v);
    endfunction

    initial begin
        int mq;
        bit mr, ml, mc;
        int nq;

        reset = 1'b1; enable = 1'b0; cin = 1'b1; mode = MODE_UP; d = '0;
        s_reset = 1'b1; s_enable = 1'b0; s_cin = 1'b1; s_mode = MODE_UP; s_d = '0;
        c_reset = 1'b1; c_enable = 1'b0; c_mode = MODE_UP; c_d = '0;

        //  rst en ci mode      D     Q     rco load cout
        add(1, 1, 1, MODE_UP,  4'h0, 4'h0, 0, 0, 0);
        add(0, 1, 1, MODE_LD,  4'h8, 4'h8, 0, 1, 0);
        add(0, 1, 1, MODE_UP,  4'h0, 4'h9, 0, 0, 0);
        add(1, 1, 1, MODE_UP,  4'h0, 4'h0, 0, 0, 0);
        add(0, 1, 1, MODE_UP,  4'h0, 4'h1, 0, 0, 0);
        add(0, 1, 1, MODE_UP,  4'h0, 4'h2, 0, 0, 0);
        add(0, 1, 1, MODE_LD,  4'hD, 4'hD, 0, 1, 0);
        add(0, 1, 1, MODE_UP,  4'h0, 4'hE, 0, 0, 0);
        add(0, 1, 1, MODE_UP,  4'h0, 4'hF, 0, 0, 1);
        add(0, 1, 1, MODE_UP,  4'h0, 4'h0, 1, 0, 0);
        add(0, 1, 1, MODE_UP,  4'h0, 4'h1, 0, 0, 0);
        add(0, 1, 1, MODE_LD,  4'h4, 4'h4, 0, 1, 0);
        add(0, 1, 1, MODE_DNS, 4'h0, 4'h1, 0, 0, 1);
        add(0, 1, 1, MODE_DNS, 4'h0, 4'hE, 1, 0, 0);
        add(0, 1, 1, MODE_DNS, 4'h0, 4'hB, 0, 0, 0);
        add(0, 0, 1, MODE_LD,  4'h5, 4'hB, 0, 0, 0);
        add(0, 1, 0, MODE_UP,  4'h0, 4'hB, 0, 0, 0);
        add(0, 1, 1, MODE_LD,  4'hF, 4'hF, 0, 1, 0);
        add(0, 1, 0, MODE_UP,  4'h0, 4'hF, 0, 0, 0);
        add(0, 1, 1, MODE_LD,  4'h1, 4'h1, 0, 1, 0);
        add(0, 1, 1, MODE_DN,  4'h0, 4'h0, 0, 0, 1);
        add(0, 1, 1, MODE_DN,  4'h0, 4'hF, 1, 0, 0);
        add(0, 0, 1, MODE_DN,  4'h0, 4'hF, 0, 0, 0);
        add(0, 1, 1, MODE_DN,  4'h0, 4'hE, 0, 0, 0);
        add(0, 1, 0, MODE_LD,  4'h7, 4'h7, 0, 1, 0);
        add(1, 1, 1, MODE_LD,  4'h9, 4'h0, 0, 0, 0);
        add(0, 1, 1, MODE_LD,  4'h3, 4'h3, 0, 1, 0);
        add(0, 1, 1, MODE_DNS, 4'h0, 4'h0, 0, 0, 1);
        add(0, 1, 1, MODE_DNS, 4'h0, 4'hD, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            reset = tbl[i].rst; enable = tbl[i].en; cin = tbl[i].ci;
            mode = tbl[i].md; d = tbl[i].dv;
            tick();
            check($sformatf("tbl%0d_q", i),    32'(q),    32'(tbl[i].eq));
            check($sformatf("tbl%0d_rco", i),  32'(rco),  32'(tbl[i].er));
            check($sformatf("tbl%0d_load", i), 32'(load), 32'(tbl[i].el));
            check($sformatf("tbl%0d_cout", i), 32'(cout), 32'(tbl[i].ec));
        end

        // ---------------- saturating instance ----------------
        tick();
        check("sat_reset_q", 32'(s_q), 32'h0);
        s_reset = 1'b0; s_enable = 1'b1; s_mode = MODE_LD; s_d = 4'h1;
        tick();
        check("sat_ld1_q", 32'(s_q), 32'h1);
        check("sat_ld1_load", 32'(s_load), 32'h1);
        s_mode = MODE_DN;
        tick();
        check("sat_dn0_q", 32'(s_q), 32'h0);
        check("sat_dn0_rco", 32'(s_rco), 32'h0);
        check("sat_dn0_cout", 32'(s_cout), 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("sat_dn_clamp%0d_q", i), 32'(s_q), 32'h0);
            check($sformatf("sat_dn_clamp%0d_rco", i), 32'(s_rco), 32'h1);
        end
        s_mode = MODE_LD; s_d = 4'hF;
        tick();
        check("sat_ldF_q", 32'(s_q), 32'hF);
        s_mode = MODE_UP;
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("sat_up_clamp%0d_q", i), 32'(s_q), 32'hF);
            check($sformatf("sat_up_clamp%0d_rco", i), 32'(s_rco), 32'h1);
        end
        s_mode = MODE_LD; s_d = 4'h2;
        tick();
        s_mode = MODE_DNS;
        tick();
        check("sat_dns_q", 32'(s_q), 32'h0);
        check("sat_dns_rco", 32'(s_rco), 32'h1);

        // ---------------- cascade ----------------
        c_reset = 1'b0; c_enable = 1'b1; c_mode = MODE_LD; c_d = 8'h0E;
        tick();
        check("cas_ld_val", 32'({hi_q, lo_q}), 32'h0E);
        check("cas_ld_load", 32'(lo_load), 32'h1);
        c_mode = MODE_UP;
        tick();
        check("cas_0f_val", 32'({hi_q, lo_q}), 32'h0F);
        check("cas_0f_lo_cout", 32'(lo_cout), 32'h1);
        check("cas_0f_lo_rco", 32'(lo_rco), 32'h0);
        tick();
        check("cas_10_val", 32'({hi_q, lo_q}), 32'h10);
        check("cas_10_lo_rco", 32'(lo_rco), 32'h1);
        check("cas_10_hi_rco", 32'(hi_rco), 32'h0);
        tick();
        check("cas_11_val", 32'({hi_q, lo_q}), 32'h11);
        check("cas_11_lo_rco", 32'(lo_rco), 32'h0);
        check("cas_11_hi_rco", 32'(hi_rco), 32'h0);
        check("cas_11_hi_cout", 32'(hi_cout), 32'h0);

        // ---------------- randomized traffic vs model ----------------
        mq = 0;
        for (int i = 0; i < 400; i++) begin
            reset  = (i == 0) || ($urandom_range(0, 24) == 0);
            enable = ($urandom_range(0, 9) < 8);
            cin    = ($urandom_range(0, 3) != 0);
            mode   = 2'($urandom_range(0, 3));
            d      = 4'($urandom_range(0, 15));
            model_next(mq, reset, enable, cin, int'(mode), int'(d), 1'b0, 3, nq, mr, ml);
            exp_q.push_back(4'(nq));
            mq = nq;
            tick();
            check($sformatf("rnd%0d_q", i), 32'(q), 32'(exp_q.pop_front()));
            check($sformatf("rnd%0d_rco", i), 32'(rco), 32'(mr));
            check($sformatf("rnd%0d_load", i), 32'(load), 32'(ml));
            mc = model_cout(mq, reset, enable, cin, int'(mode), 3);
            check($sformatf("rnd%0d_cout", i), 32'(cout), 32'(mc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
